// File: rtl/profile_counter_ci.sv
// Custom-instruction profiler: per-counter run/clear/overflow/snapshot, read back one value per request.
// Latency 1 cycle (done one cycle after accept); no backpressure, a request may arrive every cycle.
module profile_counter_ci #(
   parameter logic [7:0] customId       = 8'h00,
   parameter int         NR_OF_COUNTERS = 4,
   parameter int         COUNTER_WIDTH  = 32,
   parameter int         SATURATE       = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [7:0]                ciN,
   input  logic [31:0]               valueA,
   input  logic [31:0]               valueB,
   input  logic [NR_OF_COUNTERS-1:0] eventIn,
   output logic                      done,
   output logic [31:0]               result
);

   logic [COUNTER_WIDTH-1:0]  cnt  [NR_OF_COUNTERS];
   logic [COUNTER_WIDTH-1:0]  snap [NR_OF_COUNTERS];
   logic [NR_OF_COUNTERS-1:0] run;
   logic [NR_OF_COUNTERS-1:0] ovf;
   logic                      acc;
   logic [31:0]               rd_data;
   logic                      unused_bits;

   assign acc         = start && (ciN == customId);
   assign unused_bits = ^{valueA, valueB};

   // Read mux works on pre-edge state so a read sees values before this request's control.
   always_comb begin
      rd_data = '0;
      if (valueA[3]) begin
         rd_data[NR_OF_COUNTERS-1:0] = ovf;
      end else begin
         for (int i = 0; i < NR_OF_COUNTERS; i++) begin
            if (valueA[2:0] == 3'(i)) begin
               rd_data[COUNTER_WIDTH-1:0] = valueA[4] ? snap[i] : cnt[i];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
         run    <= '0;
         ovf    <= '0;
         for (int i = 0; i < NR_OF_COUNTERS; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
      end else begin
         done   <= acc;
         result <= acc ? rd_data : '0;
         for (int i = 0; i < NR_OF_COUNTERS; i++) begin
            if (acc && valueB[24]) begin
               snap[i] <= cnt[i];
            end
            if (acc) begin
               run[i] <= valueB[8+i] ? 1'b0 : (run[i] | valueB[i]);
            end
            // Clear beats the increment; the run bit is left alone so counting resumes from 0.
            if (acc && valueB[16+i]) begin
               cnt[i] <= '0;
               ovf[i] <= 1'b0;
            end else if (run[i] && eventIn[i]) begin
               if (&cnt[i]) begin
                  ovf[i] <= 1'b1;
                  if (SATURATE == 0) begin
                     cnt[i] <= '0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_profile_counter_ci.sv
// Bench for profile_counter_ci: three instances (32-bit wrap, 4-bit wrap, 4-bit saturate) share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_profile_counter_ci;

   localparam logic [7:0] CID = 8'h3C;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  ciN = 8'h00;
   logic [31:0] valueA = '0;
   logic [31:0] valueB = '0;
   logic [3:0]  eventIn = '0;
   logic        done0, done1, done2;
   logic [31:0] res0, res1, res2;

   int n_assert = 0;
   int n_fail   = 0;

   int     cfg_w   [3] = '{32, 4, 4};
   bit     cfg_sat [3] = '{1'b0, 1'b0, 1'b1};
   longint m_cnt  [3][4];
   longint m_snap [3][4];
   bit     m_run  [3][4];
   bit     m_ovf  [3][4];

   always #5 clock = ~clock;

   profile_counter_ci #(.customId(CID), .NR_OF_COUNTERS(4), .COUNTER_WIDTH(32), .SATURATE(0)) u_w32 (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
      .eventIn(eventIn), .done(done0), .result(res0));
   profile_counter_ci #(.customId(CID), .NR_OF_COUNTERS(4), .COUNTER_WIDTH(4), .SATURATE(0)) u_w4 (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
      .eventIn(eventIn), .done(done1), .result(res1));
   profile_counter_ci #(.customId(CID), .NR_OF_COUNTERS(4), .COUNTER_WIDTH(4), .SATURATE(1)) u_s4 (
      .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
      .eventIn(eventIn), .done(done2), .result(res2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int c, input logic [31:0] a);
      logic [31:0] r;
      int idx;
      r   = '0;
      idx = int'(a[2:0]);
      if (a[3]) begin
         for (int i = 0; i < 4; i++) r[i] = m_ovf[c][i];
      end else if (idx < 4) begin
         r = a[4] ? 32'(m_snap[c][idx]) : 32'(m_cnt[c][idx]);
      end
      return r;
   endfunction

   task automatic model_update(input bit rst, input bit acc, input logic [31:0] b, input logic [3:0] ev);
      longint maxv;
      for (int c = 0; c < 3; c++) begin
         maxv = (64'd1 << cfg_w[c]) - 1;
         for (int i = 0; i < 4; i++) begin
            if (rst) begin
               m_cnt[c][i] = 0; m_snap[c][i] = 0; m_run[c][i] = 0; m_ovf[c][i] = 0;
            end else begin
               if (acc && b[24]) m_snap[c][i] = m_cnt[c][i];
               if (acc && b[16+i]) begin
                  m_cnt[c][i] = 0;
                  m_ovf[c][i] = 0;
               end else if (m_run[c][i] && ev[i]) begin
                  if (m_cnt[c][i] == maxv) begin
                     m_ovf[c][i] = 1;
                     m_cnt[c][i] = cfg_sat[c] ? maxv : 0;
                  end else begin
                     m_cnt[c][i] = m_cnt[c][i] + 1;
                  end
               end
               if (acc) m_run[c][i] = b[8+i] ? 1'b0 : (m_run[c][i] | b[i]);
            end
         end
      end
   endtask

   // One clock: drive inputs, predict, advance the model at the edge, check away from the edge.
   task automatic cycle(input bit rst, input bit st, input logic [7:0] cin, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] ev);
      bit          acc;
      logic [31:0] exp_res [3];
      reset = rst; start = st; ciN = cin; valueA = a; valueB = b; eventIn = ev;
      acc = st && (cin == CID) && !rst;
      for (int c = 0; c < 3; c++) exp_res[c] = acc ? model_read(c, a) : 32'd0;
      @(posedge clock);
      model_update(rst, acc, b, ev);
      @(negedge clock);
      chk("done_w32", {31'd0, done0}, {31'd0, acc});
      chk("done_w4",  {31'd0, done1}, {31'd0, acc});
      chk("done_s4",  {31'd0, done2}, {31'd0, acc});
      chk("res_w32", res0, exp_res[0]);
      chk("res_w4",  res1, exp_res[1]);
      chk("res_s4",  res2, exp_res[2]);
   endtask

   task automatic idle(input int n, input logic [3:0] ev);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, CID, 32'd0, 32'd0, ev);
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ev);
      cycle(1'b0, 1'b1, CID, a, b, ev);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, CID, 32'd0, 32'd0, 4'd0);
      cycle(1'b1, 1'b0, CID, 32'd0, 32'd0, 4'd0);
   endtask

   initial begin
      logic [31:0] b;
      // Reset state and first read
      do_reset();
      chk("rst_done", {31'd0, done0}, 32'd0);
      req(32'd0, 32'd0, 4'd0);
      chk("first_done", {31'd0, done0}, 32'd1);
      chk("first_res", res0, 32'd0);
      idle(1, 4'd0);
      chk("done_drop", {31'd0, done0}, 32'd0);

      // Run, stop with last event counting
      req(32'd0, 32'h0000_0001, 4'b0001);
      idle(9, 4'b0001);
      req(32'd0, 32'h0000_0100, 4'b0001);
      chk("run_read9", res0, 32'd9);
      idle(9, 4'b0001);
      req(32'd0, 32'd0, 4'b0001);
      chk("stop_read10", res0, 32'd10);

      // Overflow, wrap vs saturate, clear with same-instruction overflow read
      do_reset();
      req(32'd0, 32'h0000_0001, 4'b0001);
      idle(17, 4'b0001);
      req(32'd0, 32'd0, 4'b0001);
      chk("ovf_cnt_w32", res0, 32'd17);
      chk("ovf_cnt_wrap", res1, 32'd1);
      chk("ovf_cnt_sat", res2, 32'd15);
      req(32'h8, 32'd0, 4'b0001);
      chk("ovf_flag_w32", res0, 32'd0);
      chk("ovf_flag_wrap", res1, 32'h1);
      chk("ovf_flag_sat", res2, 32'h1);
      req(32'h8, 32'h0001_0000, 4'b0001);
      chk("clr_ovf_old_wrap", res1, 32'h1);
      chk("clr_ovf_old_sat", res2, 32'h1);
      req(32'h8, 32'd0, 4'b0001);
      chk("clr_ovf_new_wrap", res1, 32'h0);
      chk("clr_ovf_new_sat", res2, 32'h0);

      // Stop wins over run; foreign ciN ignored; reset beats a request
      req(32'd0, 32'h0000_0202, 4'b0011);
      idle(3, 4'b0011);
      req(32'd1, 32'd0, 4'b0011);
      chk("stop_wins", res0, 32'd0);
      cycle(1'b0, 1'b1, 8'hA5, 32'd0, 32'h00FF_0000, 4'b0011);
      chk("foreign_done", {31'd0, done0}, 32'd0);
      req(32'd0, 32'd0, 4'b0011);
      req(32'd5, 32'd0, 4'b0011);
      chk("idx_oob", res0, 32'd0);
      cycle(1'b1, 1'b1, CID, 32'd0, 32'd0, 4'b0011);
      chk("rst_beats_req", {31'd0, done0}, 32'd0);
      cycle(1'b1, 1'b0, CID, 32'd0, 32'd0, 4'd0);

      // Snapshot, clear, snapshot read vs live read
      req(32'd0, 32'h0000_0004, 4'b0100);
      idle(100, 4'b0100);
      req(32'd0, 32'h0100_0000, 4'b0100);
      req(32'd0, 32'h0004_0000, 4'b0100);
      req(32'h12, 32'd0, 4'b0100);
      chk("snap_w32", res0, 32'd100);
      chk("snap_sat", res2, 32'd15);
      idle(4, 4'b0100);
      req(32'd2, 32'd0, 4'b0100);
      chk("live_after_clr", res0, 32'd5);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         b = $urandom;
         if ($urandom_range(0, 3) != 0) b[23:16] = 8'h00;
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 4) == 0) ? 8'($urandom) : CID,
               $urandom, b, 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
